if_id_fetch_stage: RTL and testbench
====================================

Name: if_id_fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the 10-bit pipelined CPU. Owns the PC and drives the asynchronous instruction ROM address. Registers the fetched instruction, its PC and a valid bit toward decode. Accepts stall from the hazard unit, redirect (branch/jump) from execute, and halt from the ALU.

Parameters:
ADDR_W, 10, PC / ROM address width
INSTR_W, 10, instruction width
RESET_PC, 10'd0, PC value loaded on reset

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
stall  in  1  hold PC and IF/ID contents (load-use or structural hazard)
redirect_valid  in  1  taken branch or jump resolved in execute
redirect_pc  in  ADDR_W  absolute target, already extended by execute
halt_req  in  1  ALU halt detected; stop fetching
imem_addr  out  ADDR_W  ROM address, equal to the current PC (combinational)
imem_rdata  in  INSTR_W  ROM data, valid in the same cycle (async ROM)
id_valid  out  1  IF/ID slot holds a real instruction
id_instr  out  INSTR_W  registered instruction
id_pc  out  ADDR_W  PC of id_instr
id_pc_plus1  out  ADDR_W  id_pc+1 mod 2^ADDR_W, used for branch-target arithmetic
fetch_halted  out  1  stage is in HALTED

Behaviour:
- Reset (rst=1 at posedge) overrides everything: pc=RESET_PC, state=RUN, id_valid=0, id_instr=0, id_pc=0, id_pc_plus1=0, fetch_halted=0. A reset mid-stall, mid-redirect or while halted gives the same result.
- imem_addr = pc at all times. One-cycle fetch latency: the instruction at pc appears on id_instr after the next posedge.
- States: RUN and HALTED. RUN->HALTED on halt_req. HALTED exits only on rst.
- Per-posedge priority in RUN: halt_req > redirect_valid > stall > normal.
- Normal: id_instr<=imem_rdata, id_pc<=pc, id_pc_plus1<=pc+1, id_valid<=1, pc<=pc+1.
- Redirect: pc<=redirect_pc, id_valid<=0, id_instr<=0. This squashes the wrong-path fetch and leaves exactly one bubble. The stall input is ignored in that cycle.
- Stall (no redirect): pc and all id_* outputs hold their values.
- halt_req: pc holds, id_valid<=0, state<=HALTED, fetch_halted<=1 (registered, visible next cycle).
- HALTED: pc frozen, id_valid stays 0, and all other inputs are ignored.
- PC arithmetic is modulo 2^ADDR_W. 1023+1 wraps to 0, both for pc and for id_pc_plus1.
- The stage does no decode. It never interprets opcodes.

Optional Feature:
Macro: IF_ID_PERF_CNT_EN.
- Defined: adds outputs perf_fetched[15:0] and perf_bubbles[15:0], both reset to 0.
  - perf_fetched increments on each normal load (id_valid<=1).
  - perf_bubbles increments on each redirect or stall cycle while in RUN.
  - Both saturate at 16'hFFFF and freeze in HALTED.
- Not defined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package cpu10_pkg: ADDR_W/INSTR_W constants, RESET_PC, NOP encoding (10'b0), and the fetch state enum (RUN, HALTED).
- One natural sub-module: if_id_pipe_reg, holding the IF/ID register with load/hold/flush controls. The PC and state machine stay in the top.

Test Plan:
- Reset, then 4 free-running cycles with ROM[0..3]=10'h001..004 -> id_instr 001,002,003,004 on successive cycles; id_pc 0..3; id_valid=1 from the first post-reset edge.
- stall=1 for 2 cycles at pc=5 -> imem_addr stays 5; id_instr/id_pc unchanged; resumes with pc=6 after stall drops.
- redirect_valid=1, redirect_pc=10'h020 at pc=7 -> next cycle id_valid=0 and imem_addr=0x020; the following cycle id_pc=0x020, id_valid=1.
- redirect and stall asserted together -> redirect wins: pc=target, one bubble, no hold.
- halt_req at pc=9 -> fetch_halted=1 next cycle; pc stays 9 and id_valid=0 for 10 cycles despite redirect/stall toggling; rst returns pc=RESET_PC.
- Force pc=10'h3FF via redirect -> next fetch has id_pc=0x3FF, id_pc_plus1=0x000, and imem_addr wraps to 0. With IF_ID_PERF_CNT_EN defined, counters match the cycle-by-cycle count of loads and bubbles.

Source files
------------

// File: rtl/cpu10_pkg.sv
// Shared constants and types for the 10-bit pipelined CPU front end.
package cpu10_pkg;

  localparam int ADDR_W  = 10;
  localparam int INSTR_W = 10;

  localparam logic [ADDR_W-1:0]  RESET_PC = '0;
  localparam logic [INSTR_W-1:0] NOP      = '0;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: load a fetched instruction, hold, flush to NOP, or kill valid only.
module if_id_pipe_reg
  import cpu10_pkg::*;
#(
  parameter int ADDR_W  = cpu10_pkg::ADDR_W,
  parameter int INSTR_W = cpu10_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               flush_i,
  input  logic               kill_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic [ADDR_W-1:0]  pc_plus1_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [ADDR_W-1:0]  pc_plus1_o
);

  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  pc_plus1_q;

  // Flush zeroes the instruction so a squashed slot looks like a NOP; kill only drops valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_q       <= '0;
      pc_plus1_q <= '0;
    end else if (load_i) begin
      valid_q    <= 1'b1;
      instr_q    <= instr_i;
      pc_q       <= pc_i;
      pc_plus1_q <= pc_plus1_i;
    end else if (flush_i) begin
      valid_q    <= 1'b0;
      instr_q    <= INSTR_W'(NOP);
    end else if (kill_i) begin
      valid_q    <= 1'b0;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus1_o = pc_plus1_q;

endmodule

// File: rtl/if_id_fetch_stage.sv
// Fetch stage: owns the PC and RUN/HALTED state, feeds the IF/ID register.
// Optional IF_ID_PERF_CNT_EN adds saturating fetched/bubble counters.
module if_id_fetch_stage
  import cpu10_pkg::*;
#(
  parameter int                ADDR_W   = cpu10_pkg::ADDR_W,
  parameter int                INSTR_W  = cpu10_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = cpu10_pkg::RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [ADDR_W-1:0]  id_pc_plus1,
`ifdef IF_ID_PERF_CNT_EN
  output logic [15:0]        perf_fetched,
  output logic [15:0]        perf_bubbles,
`endif
  output logic               fetch_halted
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_plus1;
  logic              load, flush, kill, bubble;

  assign pc_plus1 = pc_q + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Priority in RUN: halt > redirect > stall > normal fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    flush   = 1'b0;
    kill    = 1'b0;
    bubble  = 1'b0;
    if (state_q == RUN) begin
      if (halt_req) begin
        state_d = HALTED;
        kill    = 1'b1;
      end else if (redirect_valid) begin
        pc_d   = redirect_pc;
        flush  = 1'b1;
        bubble = 1'b1;
      end else if (stall) begin
        bubble = 1'b1;
      end else begin
        pc_d = pc_plus1;
        load = 1'b1;
      end
    end
  end

  if_id_pipe_reg #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_pipe (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .flush_i    (flush),
    .kill_i     (kill),
    .instr_i    (imem_rdata),
    .pc_i       (pc_q),
    .pc_plus1_i (pc_plus1),
    .valid_o    (id_valid),
    .instr_o    (id_instr),
    .pc_o       (id_pc),
    .pc_plus1_o (id_pc_plus1)
  );

  assign imem_addr    = pc_q;
  assign fetch_halted = (state_q == HALTED);

`ifdef IF_ID_PERF_CNT_EN
  logic [15:0] fetched_q, bubbles_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= '0;
      bubbles_q <= '0;
    end else begin
      if (load)   fetched_q <= sat_inc(fetched_q);
      if (bubble) bubbles_q <= sat_inc(bubbles_q);
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed table-driven bench for if_id_fetch_stage (IF_ID_PERF_CNT_EN optional).
module tb_if_id_fetch_stage;

  logic       clk = 1'b0;
  logic       rst, stall, redirect_valid, halt_req;
  logic [9:0] redirect_pc;
  logic [9:0] imem_addr, imem_rdata;
  logic       id_valid, fetch_halted;
  logic [9:0] id_instr, id_pc, id_pc_plus1;
`ifdef IF_ID_PERF_CNT_EN
  logic [15:0] perf_fetched, perf_bubbles;
  int          m_fetched, m_bubbles;
  logic        m_halted;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  if_id_fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt_req      (halt_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_pc_plus1   (id_pc_plus1),
`ifdef IF_ID_PERF_CNT_EN
    .perf_fetched  (perf_fetched),
    .perf_bubbles  (perf_bubbles),
`endif
    .fetch_halted  (fetch_halted)
  );

  // ROM image: low addresses hold addr+1, elsewhere a scrambled pattern.
  function automatic logic [9:0] rom(input logic [9:0] a);
    return (a < 10'd16) ? a + 10'd1 : a ^ 10'h2AA;
  endfunction

  always_comb imem_rdata = rom(imem_addr);

  typedef struct {
    logic       rst, stall, rv, halt;
    logic [9:0] rpc;
    logic [9:0] e_addr;
    logic       e_v;
    logic [9:0] e_instr, e_pc, e_pc1;
    logic       e_h;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s, input logic rv, input logic [9:0] rpc,
                              input logic h, input logic [9:0] ea, input logic ev,
                              input logic [9:0] ei, input logic [9:0] ep, input logic [9:0] ep1,
                              input logic eh);
    vec_t v;
    v.rst = r; v.stall = s; v.rv = rv; v.rpc = rpc; v.halt = h;
    v.e_addr = ea; v.e_v = ev; v.e_instr = ei; v.e_pc = ep; v.e_pc1 = ep1; v.e_h = eh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    rst = v.rst; stall = v.stall; redirect_valid = v.rv; redirect_pc = v.rpc; halt_req = v.halt;
`ifdef IF_ID_PERF_CNT_EN
    if (v.rst) begin
      m_fetched = 0; m_bubbles = 0; m_halted = 1'b0;
    end else if (!m_halted) begin
      if (v.halt) m_halted = 1'b1;
      else if (v.rv || v.stall) m_bubbles++;
      else m_fetched++;
    end
`endif
    @(posedge clk);
    #1;
    chk({tag, ".imem_addr"},    imem_addr,    v.e_addr);
    chk({tag, ".id_valid"},     id_valid,     v.e_v);
    chk({tag, ".id_instr"},     id_instr,     v.e_instr);
    chk({tag, ".id_pc"},        id_pc,        v.e_pc);
    chk({tag, ".id_pc_plus1"},  id_pc_plus1,  v.e_pc1);
    chk({tag, ".fetch_halted"}, fetch_halted, v.e_h);
`ifdef IF_ID_PERF_CNT_EN
    chk({tag, ".perf_fetched"}, perf_fetched, m_fetched);
    chk({tag, ".perf_bubbles"}, perf_bubbles, m_bubbles);
`endif
  endtask

  vec_t vt[20];

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0;
`ifdef IF_ID_PERF_CNT_EN
    m_fetched = 0; m_bubbles = 0; m_halted = 1'b0;
`endif
    //          rst  stl  rv  rpc      halt addr     v  instr    pc       pc+1     h
    vt[0]  = mk(1,   0,   0,  10'h000, 0,   10'h000, 0, 10'h000, 10'h000, 10'h000, 0);
    vt[1]  = mk(0,   0,   0,  10'h000, 0,   10'h001, 1, 10'h001, 10'h000, 10'h001, 0);
    vt[2]  = mk(0,   0,   0,  10'h000, 0,   10'h002, 1, 10'h002, 10'h001, 10'h002, 0);
    vt[3]  = mk(0,   0,   0,  10'h000, 0,   10'h003, 1, 10'h003, 10'h002, 10'h003, 0);
    vt[4]  = mk(0,   0,   0,  10'h000, 0,   10'h004, 1, 10'h004, 10'h003, 10'h004, 0);
    vt[5]  = mk(0,   0,   0,  10'h000, 0,   10'h005, 1, 10'h005, 10'h004, 10'h005, 0);
    vt[6]  = mk(0,   1,   0,  10'h000, 0,   10'h005, 1, 10'h005, 10'h004, 10'h005, 0);
    vt[7]  = mk(0,   1,   0,  10'h000, 0,   10'h005, 1, 10'h005, 10'h004, 10'h005, 0);
    vt[8]  = mk(0,   0,   0,  10'h000, 0,   10'h006, 1, 10'h006, 10'h005, 10'h006, 0);
    vt[9]  = mk(0,   0,   0,  10'h000, 0,   10'h007, 1, 10'h007, 10'h006, 10'h007, 0);
    vt[10] = mk(0,   0,   1,  10'h020, 0,   10'h020, 0, 10'h000, 10'h006, 10'h007, 0);
    vt[11] = mk(0,   0,   0,  10'h000, 0,   10'h021, 1, 10'h28A, 10'h020, 10'h021, 0);
    vt[12] = mk(0,   1,   1,  10'h040, 0,   10'h040, 0, 10'h000, 10'h020, 10'h021, 0);
    vt[13] = mk(0,   1,   0,  10'h000, 0,   10'h040, 0, 10'h000, 10'h020, 10'h021, 0);
    vt[14] = mk(0,   0,   0,  10'h000, 0,   10'h041, 1, 10'h2EA, 10'h040, 10'h041, 0);
    vt[15] = mk(0,   0,   1,  10'h3FF, 0,   10'h3FF, 0, 10'h000, 10'h040, 10'h041, 0);
    vt[16] = mk(0,   0,   0,  10'h000, 0,   10'h000, 1, 10'h155, 10'h3FF, 10'h000, 0);
    vt[17] = mk(0,   0,   0,  10'h000, 0,   10'h001, 1, 10'h001, 10'h000, 10'h001, 0);
    vt[18] = mk(0,   0,   1,  10'h009, 0,   10'h009, 0, 10'h000, 10'h000, 10'h001, 0);
    // Halt at pc=9 with redirect and stall also asserted: halt wins.
    vt[19] = mk(0,   1,   1,  10'h100, 1,   10'h009, 0, 10'h000, 10'h000, 10'h001, 1);

    for (int i = 0; i < 20; i++) step(vt[i], $sformatf("vec%0d", i));

    // Frozen while halted regardless of redirect/stall/halt activity.
    for (int i = 0; i < 10; i++)
      step(mk(0, i[0], i[1], 10'h100, (i % 3) == 0,
              10'h009, 0, 10'h000, 10'h000, 10'h001, 1), $sformatf("halted%0d", i));

    // Reset while halted with other inputs active, then fetch resumes from RESET_PC.
    step(mk(1, 1, 1, 10'h100, 1, 10'h000, 0, 10'h000, 10'h000, 10'h000, 0), "rst_halted");
    step(mk(0, 0, 0, 10'h000, 0, 10'h001, 1, 10'h001, 10'h000, 10'h001, 0), "post_rst");
    step(mk(0, 1, 0, 10'h000, 0, 10'h001, 1, 10'h001, 10'h000, 10'h001, 0), "stall_a");
    // Reset in the middle of a stall.
    step(mk(1, 1, 0, 10'h000, 0, 10'h000, 0, 10'h000, 10'h000, 10'h000, 0), "rst_stall");
    // Reset in the middle of a redirect.
    step(mk(1, 0, 1, 10'h0F0, 0, 10'h000, 0, 10'h000, 10'h000, 10'h000, 0), "rst_redir");
    step(mk(0, 0, 0, 10'h000, 0, 10'h001, 1, 10'h001, 10'h000, 10'h001, 0), "post_rst2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
